// File: rtl/tl_inflight_monitor.sv
// Passive TileLink-UL/UH checker: tracks outstanding sources on one A/D pair,
// counts beats, and reports protocol errors one cycle after the offending edge.
module tl_inflight_monitor #(
  parameter int unsigned SOURCE_BITS = 4,
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned SIZE_BITS   = 3,
  parameter int unsigned BEAT_LG     = 3,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic [2**BEAT_LG-1:0]  a_mask,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  output logic                   err_valid,
  output logic [3:0]             err_code,
  output logic [SOURCE_BITS-1:0] err_source,
  output logic [15:0]            err_sticky,
  output logic [SOURCE_BITS:0]   inflight_cnt
);

  localparam int unsigned NSRC     = 2**SOURCE_BITS;
  localparam int unsigned MASK_W   = 2**BEAT_LG;
  localparam int unsigned MAX_SIZE = 2**SIZE_BITS - 1;
  localparam int unsigned CNT_W    = (MAX_SIZE > BEAT_LG) ? MAX_SIZE - BEAT_LG + 1 : 1;
  localparam int unsigned TMR_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit               TMO_EN   = (TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] beats(input logic [SIZE_BITS-1:0] sz);
    if (32'(sz) > BEAT_LG) beats = CNT_W'(1) << (32'(sz) - BEAT_LG);
    else                   beats = CNT_W'(1);
  endfunction

  function automatic logic [2:0] exp_resp(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: exp_resp = 3'd0;
      3'd5:       exp_resp = 3'd2;
      default:    exp_resp = 3'd1;
    endcase
  endfunction

  logic                   a_fire, a_first, a_ffire, d_fire, d_first, d_ffire, d_last;
  logic [CNT_W-1:0]       a_beats, d_beats, a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
  logic [SOURCE_BITS-1:0] a_src_q, a_src_d, tmo_src;
  logic [NSRC-1:0]        inflight_q, inflight_d, set_vec, clr_vec, tmo_vec;
  logic [SIZE_BITS-1:0]   size_tab_q [NSRC];
  logic [SIZE_BITS-1:0]   size_tab_d [NSRC];
  logic [2:0]             op_tab_q [NSRC];
  logic [2:0]             op_tab_d [NSRC];
  logic [TMR_W-1:0]       timer_q [NSRC];
  logic [TMR_W-1:0]       timer_d [NSRC];
  logic [ADDR_BITS-1:0]   align_mask;
  logic                   zero_lat, tmo_found;
  logic [2:0]             rec_op;
  logic [SIZE_BITS-1:0]   rec_size;
  logic [15:0]            errs;
  logic [3:0]             err_code_d;
  logic [SOURCE_BITS-1:0] err_src_d;
  logic [SOURCE_BITS:0]   cnt_d;

  // Held A/D snapshots for the stability checks
  logic                   a_hold_q, d_hold_q;
  logic [2:0]             a_hold_op_q, d_hold_op_q;
  logic [SIZE_BITS-1:0]   a_hold_size_q, d_hold_size_q;
  logic [SOURCE_BITS-1:0] a_hold_src_q, d_hold_src_q;
  logic [ADDR_BITS-1:0]   a_hold_addr_q;
  logic [MASK_W-1:0]      a_hold_mask_q;

  logic                   err_valid_q;
  logic [3:0]             err_code_q;
  logic [SOURCE_BITS-1:0] err_source_q;
  logic [15:0]            err_sticky_q;
  logic [SOURCE_BITS:0]   inflight_cnt_q;

  // Beat accounting, inflight/table/timer next state and error detection
  always_comb begin
    a_fire  = a_valid & a_ready;
    a_first = (a_cnt_q == '0);
    a_ffire = a_fire & a_first;
    a_beats = (a_opcode <= 3'd3) ? beats(a_size) : CNT_W'(1);
    a_cnt_d = a_cnt_q;
    if (a_fire) a_cnt_d = a_first ? a_beats - CNT_W'(1) : a_cnt_q - CNT_W'(1);
    a_src_d = a_ffire ? a_source : a_src_q;

    d_fire  = d_valid & d_ready;
    d_first = (d_cnt_q == '0);
    d_ffire = d_fire & d_first;
    d_beats = (d_opcode == 3'd1) ? beats(d_size) : CNT_W'(1);
    d_last  = d_fire & (d_first ? (d_beats == CNT_W'(1)) : (d_cnt_q == CNT_W'(1)));
    d_cnt_d = d_cnt_q;
    if (d_fire) d_cnt_d = d_first ? d_beats - CNT_W'(1) : d_cnt_q - CNT_W'(1);

    set_vec = '0;
    clr_vec = '0;
    if (a_ffire) set_vec[a_source] = 1'b1;
    if (d_last)  clr_vec[d_source] = 1'b1;
    // Clear applied after set so a same-cycle completion wins
    inflight_d = (inflight_q | set_vec) & ~clr_vec;

    size_tab_d = size_tab_q;
    op_tab_d   = op_tab_q;
    if (a_ffire) begin
      size_tab_d[a_source] = a_size;
      op_tab_d[a_source]   = a_opcode;
    end

    tmo_src   = '0;
    tmo_found = 1'b0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      timer_d[s] = timer_q[s];
      if (set_vec[s] || clr_vec[s])
        timer_d[s] = '0;
      else if (inflight_q[s] && timer_q[s] != TMR_MAX)
        timer_d[s] = timer_q[s] + 1'b1;
      tmo_vec[s] = TMO_EN && inflight_q[s] && !clr_vec[s] && (timer_q[s] == TMR_LAST);
      if (tmo_vec[s] && !tmo_found) begin
        tmo_src   = SOURCE_BITS'(s);
        tmo_found = 1'b1;
      end
    end

    // A zero-latency response checks against the request firing this cycle
    zero_lat   = a_ffire && (a_source == d_source) && !inflight_q[d_source];
    rec_op     = zero_lat ? a_opcode : op_tab_q[d_source];
    rec_size   = zero_lat ? a_size   : size_tab_q[d_source];
    align_mask = ~({ADDR_BITS{1'b1}} << a_size);

    errs     = '0;
    errs[1]  = a_ffire && (a_opcode >= 3'd6);
    errs[2]  = a_ffire && ((a_address & align_mask) != '0);
    errs[3]  = a_ffire && (a_mask == '0);
    errs[4]  = a_ffire && inflight_q[a_source];
    errs[5]  = a_hold_q && (!a_valid || a_opcode != a_hold_op_q || a_size != a_hold_size_q ||
                            a_source != a_hold_src_q || a_address != a_hold_addr_q ||
                            a_mask != a_hold_mask_q);
    errs[6]  = d_hold_q && (!d_valid || d_opcode != d_hold_op_q || d_size != d_hold_size_q ||
                            d_source != d_hold_src_q);
    errs[7]  = d_ffire && !inflight_q[d_source] && !(a_ffire && a_source == d_source);
    errs[8]  = d_ffire && !errs[7] && (d_opcode != exp_resp(rec_op));
    errs[9]  = d_ffire && !errs[7] && (d_size != rec_size);
    errs[10] = d_fire && (a_cnt_d != '0) && (d_source == a_src_d);
    errs[11] = |tmo_vec;

    err_code_d = '0;
    for (int unsigned i = 11; i >= 1; i--)
      if (errs[i]) err_code_d = 4'(i);
    case (err_code_d)
      4'd1, 4'd2, 4'd3, 4'd4:  err_src_d = a_source;
      4'd5:                    err_src_d = a_hold_src_q;
      4'd6:                    err_src_d = d_hold_src_q;
      4'd7, 4'd8, 4'd9, 4'd10: err_src_d = d_source;
      4'd11:                   err_src_d = tmo_src;
      default:                 err_src_d = '0;
    endcase

    cnt_d = '0;
    for (int unsigned s = 0; s < NSRC; s++)
      cnt_d = cnt_d + {{SOURCE_BITS{1'b0}}, inflight_d[s]};
  end

  // Tracking state: beat counters, bitmap, tables, timers, snapshots
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_cnt_q       <= '0;
      d_cnt_q       <= '0;
      a_src_q       <= '0;
      inflight_q    <= '0;
      a_hold_q      <= 1'b0;
      a_hold_op_q   <= '0;
      a_hold_size_q <= '0;
      a_hold_src_q  <= '0;
      a_hold_addr_q <= '0;
      a_hold_mask_q <= '0;
      d_hold_q      <= 1'b0;
      d_hold_op_q   <= '0;
      d_hold_size_q <= '0;
      d_hold_src_q  <= '0;
      for (int unsigned s = 0; s < NSRC; s++) begin
        size_tab_q[s] <= '0;
        op_tab_q[s]   <= '0;
        timer_q[s]    <= '0;
      end
    end else begin
      a_cnt_q    <= a_cnt_d;
      d_cnt_q    <= d_cnt_d;
      a_src_q    <= a_src_d;
      inflight_q <= inflight_d;
      size_tab_q <= size_tab_d;
      op_tab_q   <= op_tab_d;
      timer_q    <= timer_d;
      a_hold_q   <= a_valid & ~a_ready;
      d_hold_q   <= d_valid & ~d_ready;
      if (a_valid && !a_ready) begin
        a_hold_op_q   <= a_opcode;
        a_hold_size_q <= a_size;
        a_hold_src_q  <= a_source;
        a_hold_addr_q <= a_address;
        a_hold_mask_q <= a_mask;
      end
      if (d_valid && !d_ready) begin
        d_hold_op_q   <= d_opcode;
        d_hold_size_q <= d_size;
        d_hold_src_q  <= d_source;
      end
    end
  end

  // Registered error reporting and inflight count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_valid_q    <= 1'b0;
      err_code_q     <= '0;
      err_source_q   <= '0;
      err_sticky_q   <= '0;
      inflight_cnt_q <= '0;
    end else begin
      err_valid_q    <= |errs;
      err_code_q     <= err_code_d;
      err_source_q   <= err_src_d;
      err_sticky_q   <= err_sticky_q | errs;
      inflight_cnt_q <= cnt_d;
    end
  end

  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign err_source   = err_source_q;
  assign err_sticky   = err_sticky_q;
  assign inflight_cnt = inflight_cnt_q;

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Directed bench for tl_inflight_monitor with TIMEOUT=16.
module tb_tl_inflight_monitor;

  localparam int unsigned SB = 4;
  localparam int unsigned AB = 32;
  localparam int unsigned ZB = 3;
  localparam int unsigned BL = 3;
  localparam int unsigned TO = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          a_valid, a_ready, d_valid, d_ready;
  logic [2:0]    a_opcode, d_opcode;
  logic [ZB-1:0] a_size, d_size;
  logic [SB-1:0] a_source, d_source;
  logic [AB-1:0] a_address;
  logic [7:0]    a_mask;
  logic          err_valid;
  logic [3:0]    err_code;
  logic [SB-1:0] err_source;
  logic [15:0]   err_sticky;
  logic [SB:0]   inflight_cnt;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clock = ~clock;

  tl_inflight_monitor #(
    .SOURCE_BITS(SB), .ADDR_BITS(AB), .SIZE_BITS(ZB), .BEAT_LG(BL), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source),
    .err_valid(err_valid), .err_code(err_code), .err_source(err_source),
    .err_sticky(err_sticky), .inflight_cnt(inflight_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic v, input logic [3:0] code,
                         input logic [SB-1:0] src);
    chk({tag, ".valid"}, {31'b0, err_valid}, {31'b0, v});
    chk({tag, ".code"}, {28'b0, err_code}, {28'b0, code});
    chk({tag, ".src"}, {28'b0, err_source}, {28'b0, src});
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic r, input logic [2:0] op, input logic [ZB-1:0] sz,
                       input logic [SB-1:0] src, input logic [AB-1:0] addr, input logic [7:0] mask);
    a_valid = v; a_ready = r; a_opcode = op; a_size = sz;
    a_source = src; a_address = addr; a_mask = mask;
  endtask

  task automatic drv_d(input logic v, input logic r, input logic [2:0] op, input logic [ZB-1:0] sz,
                       input logic [SB-1:0] src);
    d_valid = v; d_ready = r; d_opcode = op; d_size = sz; d_source = src;
  endtask

  task automatic idle;
    drv_a(0, 0, 3'd0, '0, '0, '0, '0);
    drv_d(0, 0, 3'd0, '0, '0);
  endtask

  task automatic do_reset(input string tag);
    idle();
    reset_n = 1'b0;
    #1;
    chk_err(tag, 1'b0, 4'd0, 4'd0);
    chk({tag, ".sticky"}, {16'b0, err_sticky}, 32'h0);
    chk({tag, ".cnt"}, {27'b0, inflight_cnt}, 32'd0);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    chk_err("rst", 1'b0, 4'd0, 4'd0);
    chk("rst.sticky", {16'b0, err_sticky}, 32'h0);
    chk("rst.cnt", {27'b0, inflight_cnt}, 32'd0);
    reset_n = 1'b1;

    // T1: Get src3 size3, AccessAckData five cycles later
    drv_a(1, 1, 3'd4, 3'd3, 4'd3, 32'h40, 8'hff);
    tick();
    chk_err("T1.a", 1'b0, 4'd0, 4'd0);
    chk("T1.cnt1", {27'b0, inflight_cnt}, 32'd1);
    idle();
    for (int i = 0; i < 4; i++) tick();
    chk("T1.cnt_wait", {27'b0, inflight_cnt}, 32'd1);
    drv_d(1, 1, 3'd1, 3'd3, 4'd3);
    tick();
    chk_err("T1.d", 1'b0, 4'd0, 4'd0);
    chk("T1.cnt0", {27'b0, inflight_cnt}, 32'd0);
    idle();

    // Two-beat AccessAckData: bit clears only on the last beat
    drv_a(1, 1, 3'd4, 3'd4, 4'd4, 32'h10, 8'hff);
    tick();
    chk("MB.cnt_a", {27'b0, inflight_cnt}, 32'd1);
    idle();
    drv_d(1, 1, 3'd1, 3'd4, 4'd4);
    tick();
    chk_err("MB.d1", 1'b0, 4'd0, 4'd0);
    chk("MB.cnt_d1", {27'b0, inflight_cnt}, 32'd1);
    tick();
    chk_err("MB.d2", 1'b0, 4'd0, 4'd0);
    chk("MB.cnt_d2", {27'b0, inflight_cnt}, 32'd0);
    idle();

    // T2a: PutFull src2 size5 (4 beats) then AccessAck
    drv_a(1, 1, 3'd0, 3'd5, 4'd2, 32'h20, 8'hff);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_err($sformatf("T2a.beat%0d", i), 1'b0, 4'd0, 4'd0);
    end
    chk("T2a.cnt", {27'b0, inflight_cnt}, 32'd1);
    idle();
    drv_d(1, 1, 3'd0, 3'd5, 4'd2);
    tick();
    chk_err("T2a.d", 1'b0, 4'd0, 4'd0);
    chk("T2a.cnt0", {27'b0, inflight_cnt}, 32'd0);
    chk("T2a.sticky", {16'b0, err_sticky}, 32'h0);
    idle();

    // T2b: reuse of src2 before its response
    drv_a(1, 1, 3'd0, 3'd5, 4'd2, 32'h20, 8'hff);
    for (int i = 0; i < 4; i++) tick();
    drv_a(1, 1, 3'd4, 3'd3, 4'd2, 32'h8, 8'hff);
    tick();
    chk_err("T2b.e4", 1'b1, 4'd4, 4'd2);
    chk("T2b.cnt", {27'b0, inflight_cnt}, 32'd1);
    chk("T2b.sticky", {16'b0, err_sticky}, 32'h0010);
    idle();
    tick();
    chk_err("T2b.pulse", 1'b0, 4'd0, 4'd0);
    do_reset("R1");

    // T3: stalled A changes address; then D drops valid while stalled
    drv_a(1, 0, 3'd4, 3'd3, 4'd5, 32'h100, 8'hff);
    tick();
    chk_err("T3.stall", 1'b0, 4'd0, 4'd0);
    drv_a(1, 0, 3'd4, 3'd3, 4'd5, 32'h108, 8'hff);
    tick();
    chk_err("T3.e5", 1'b1, 4'd5, 4'd5);
    drv_a(1, 1, 3'd4, 3'd3, 4'd5, 32'h108, 8'hff);
    tick();
    chk_err("T3.fire", 1'b0, 4'd0, 4'd0);
    chk("T3.cnt", {27'b0, inflight_cnt}, 32'd1);
    idle();
    drv_d(1, 0, 3'd1, 3'd3, 4'd5);
    tick();
    chk_err("E6.stall", 1'b0, 4'd0, 4'd0);
    drv_d(0, 0, 3'd1, 3'd3, 4'd5);
    tick();
    chk_err("E6.drop", 1'b1, 4'd6, 4'd5);
    drv_d(1, 1, 3'd1, 3'd3, 4'd5);
    tick();
    chk_err("E6.fire", 1'b0, 4'd0, 4'd0);
    chk("E6.cnt", {27'b0, inflight_cnt}, 32'd0);
    chk("E6.sticky", {16'b0, err_sticky}, 32'h0060);
    do_reset("R2");

    // T4: unsolicited response, then wrong response opcode
    drv_d(1, 1, 3'd0, 3'd3, 4'd7);
    tick();
    chk_err("T4.e7", 1'b1, 4'd7, 4'd7);
    idle();
    drv_a(1, 1, 3'd4, 3'd3, 4'd3, 32'h0, 8'hff);
    tick();
    chk_err("T4.get", 1'b0, 4'd0, 4'd0);
    idle();
    drv_d(1, 1, 3'd0, 3'd3, 4'd3);
    tick();
    chk_err("T4.e8", 1'b1, 4'd8, 4'd3);
    chk("T4.cnt", {27'b0, inflight_cnt}, 32'd0);
    idle();

    // Size mismatch on response
    drv_a(1, 1, 3'd4, 3'd2, 4'd6, 32'h4, 8'h0f);
    tick();
    idle();
    drv_d(1, 1, 3'd1, 3'd3, 4'd6);
    tick();
    chk_err("E9", 1'b1, 4'd9, 4'd6);
    chk("E9.sticky", {16'b0, err_sticky}, 32'h0380);
    idle();

    // Zero-latency response: same-cycle set and clear, clear wins
    drv_a(1, 1, 3'd4, 3'd3, 4'd9, 32'h18, 8'hff);
    drv_d(1, 1, 3'd1, 3'd3, 4'd9);
    tick();
    chk_err("ZL", 1'b0, 4'd0, 4'd0);
    chk("ZL.cnt", {27'b0, inflight_cnt}, 32'd0);
    idle();

    // Illegal opcode + misaligned + empty mask: lowest code wins, all sticky
    drv_a(1, 1, 3'd6, 3'd2, 4'd10, 32'h3, 8'h00);
    tick();
    chk_err("E123", 1'b1, 4'd1, 4'd10);
    chk("E123.sticky", {16'b0, err_sticky}, 32'h038e);
    do_reset("R3");

    // D fires while a two-beat PutFull on the same source is incomplete
    drv_a(1, 1, 3'd0, 3'd4, 4'd11, 32'h10, 8'hff);
    tick();
    chk_err("E10.a1", 1'b0, 4'd0, 4'd0);
    idle();
    drv_d(1, 1, 3'd0, 3'd4, 4'd11);
    tick();
    chk_err("E10", 1'b1, 4'd10, 4'd11);
    do_reset("R4");

    // T5: Get src1 never answered; single timeout pulse 16 edges after the A fire
    drv_a(1, 1, 3'd4, 3'd3, 4'd1, 32'h0, 8'hff);
    tick();
    chk_err("T5.a", 1'b0, 4'd0, 4'd0);
    idle();
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (err_valid === 1'b1) pulses++;
      chk_err($sformatf("T5.c%0d", i), (i == 16), (i == 16) ? 4'd11 : 4'd0,
              (i == 16) ? 4'd1 : 4'd0);
    end
    chk("T5.pulses", pulses, 32'd1);
    chk("T5.sticky", {16'b0, err_sticky}, 32'h0800);
    do_reset("R5");

    // T6: reset in the middle of a PutFull, then a fresh Get src0
    drv_a(1, 1, 3'd0, 3'd5, 4'd2, 32'h20, 8'hff);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drv_a(1, 1, 3'd4, 3'd3, 4'd0, 32'h0, 8'hff);
    tick();
    chk_err("T6.get", 1'b0, 4'd0, 4'd0);
    chk("T6.cnt", {27'b0, inflight_cnt}, 32'd1);
    idle();
    tick();
    chk_err("T6.idle", 1'b0, 4'd0, 4'd0);
    chk("T6.cnt2", {27'b0, inflight_cnt}, 32'd1);
    chk("T6.sticky", {16'b0, err_sticky}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
